// File: rtl/updown_sweep_ctrl_if.sv
// Counter control bus between the sweep sequencer and the 4-bit up/down counter.
// Latency: none; the bus only carries wires.
// Backpressure: none; the counter obeys dir/load on every clock.
// Ports: ctr_val (counter -> sequencer), ctr_dir/ctr_load/ctr_ldata (sequencer -> counter).
interface updown_sweep_ctrl_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] ctr_val;
   logic             ctr_dir;
   logic             ctr_load;
   logic [WIDTH-1:0] ctr_ldata;

   // Sequencer side
   modport master (
      input  ctr_val,
      output ctr_dir,
      output ctr_load,
      output ctr_ldata
   );

   // Counter side
   modport slave (
      output ctr_val,
      input  ctr_dir,
      input  ctr_load,
      input  ctr_ldata
   );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Sweeps an external up/down counter lo -> hi -> lo, n_sweeps times, turning on its read-back value.
// Latency: counter commands are combinational from state and ctr_val; done/err are registered 1-cycle pulses.
// Backpressure: start is ignored while busy; optional pause (SWEEP_PAUSE_EN) stalls the sweep in place.
// Ports: clk, rst (sync, active-low), start, abort, lo_lim, hi_lim, n_sweeps,
//        pause (only when SWEEP_PAUSE_EN is defined), cbus (counter bus, master side),
//        busy, done, err, sweep_cnt.
module updown_sweep_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] lo_lim,
   input  logic [WIDTH-1:0] hi_lim,
   input  logic [CNT_W-1:0] n_sweeps,
`ifdef SWEEP_PAUSE_EN
   input  logic             pause,
`endif
   updown_sweep_ctrl_if.master cbus,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] sweep_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_UP   = 2'd2,
      S_DOWN = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] sweep_cnt_q, sweep_cnt_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [CNT_W-1:0] sweep_inc;
   logic             out_of_range;
   logic             paused;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         lo_q        <= '0;
         hi_q        <= '0;
         n_q         <= '0;
         sweep_cnt_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         n_q         <= n_d;
         sweep_cnt_q <= sweep_cnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      n_d         = n_q;
      sweep_cnt_d = sweep_cnt_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      // Default command: reload the counter with its own value, i.e. hold it.
      cbus.ctr_dir   = 1'b1;
      cbus.ctr_load  = 1'b1;
      cbus.ctr_ldata = cbus.ctr_val;

      sweep_inc    = sweep_cnt_q + CNT_W'(1);
      out_of_range = (cbus.ctr_val < lo_q) || (cbus.ctr_val > hi_q);
`ifdef SWEEP_PAUSE_EN
      paused = pause;
`else
      paused = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (lo_lim >= hi_lim) begin
                  err_d = 1'b1;
               end else if (n_sweeps == '0) begin
                  done_d = 1'b1;
               end else begin
                  lo_d        = lo_lim;
                  hi_d        = hi_lim;
                  n_d         = n_sweeps;
                  sweep_cnt_d = '0;
                  state_d     = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               cbus.ctr_ldata = lo_q;
               state_d        = S_UP;
            end
         end

         S_UP, S_DOWN: begin
            // Priority: abort, then corruption of the fed-back value, then pause.
            if (abort) begin
               state_d = S_IDLE;
            end else if (out_of_range) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (!paused) begin
               cbus.ctr_load = 1'b0;
               if (state_q == S_UP) begin
                  // Turn in the same cycle the limit is seen so the counter never overshoots.
                  if (cbus.ctr_val == hi_q) begin
                     cbus.ctr_dir = 1'b0;
                     state_d      = S_DOWN;
                  end
               end else if (cbus.ctr_val == lo_q) begin
                  sweep_cnt_d = sweep_inc;
                  if (sweep_inc == n_q) begin
                     cbus.ctr_load  = 1'b1;
                     cbus.ctr_ldata = lo_q;
                     done_d         = 1'b1;
                     state_d        = S_IDLE;
                  end else begin
                     state_d = S_UP;
                  end
               end else begin
                  cbus.ctr_dir = 1'b0;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl with a behavioural 4-bit up/down counter in the loop.
// Inputs change and outputs are checked on the falling clock edge.
module tb_updown_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] lo_lim = '0;
   logic [3:0] hi_lim = '0;
   logic [3:0] n_sweeps = '0;
`ifdef SWEEP_PAUSE_EN
   logic       pause = 1'b0;
`endif
   logic       busy, done, err;
   logic [3:0] sweep_cnt;

   logic       corrupt = 1'b0;
   logic [3:0] corrupt_val = '0;
   logic [3:0] cnt;

   int tests = 0;
   int fails = 0;

   logic [3:0] t2_seq [0:12] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2,
                                 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
   logic       t2_dir [0:11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef SWEEP_PAUSE_EN
   logic [3:0] t6_seq [0:9] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2};
`endif

   updown_sweep_ctrl_if #(.WIDTH(4)) cbus ();

   updown_sweep_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .lo_lim    (lo_lim),
      .hi_lim    (hi_lim),
      .n_sweeps  (n_sweeps),
`ifdef SWEEP_PAUSE_EN
      .pause     (pause),
`endif
      .cbus      (cbus),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .sweep_cnt (sweep_cnt)
   );

   always #5 clk = ~clk;

   // The counter being sequenced: load wins, else step by dir. corrupt injects an illegal value.
   always @(posedge clk) begin
      if (!rst)                 cnt <= '0;
      else if (corrupt)         cnt <= corrupt_val;
      else if (cbus.ctr_load)   cnt <= cbus.ctr_ldata;
      else if (cbus.ctr_dir)    cnt <= cnt + 4'd1;
      else                      cnt <= cnt - 4'd1;
   end
   assign cbus.ctr_val = cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Presents a start pulse for one rising edge; returns on the following falling edge.
   task automatic launch(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] n);
      lo_lim   = lo;
      hi_lim   = hi;
      n_sweeps = n;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      #1;
   endtask

   initial begin
      // Reset
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_sweep_cnt", sweep_cnt, 0);
      chk("rst_load", cbus.ctr_load, 1);
      chk("rst_ldata", cbus.ctr_ldata, 0);

      // T2: two sweeps 2..5; mid-run limit changes and a stray start are ignored
      launch(4'd2, 4'd5, 4'd2);
      chk("t2_load_busy", busy, 1);
      chk("t2_load_cmd", cbus.ctr_load, 1);
      chk("t2_load_ldata", cbus.ctr_ldata, 2);
      for (int i = 0; i < 13; i++) begin
         tick();
         #1;
         chk($sformatf("t2_ctr_%0d", i), cbus.ctr_val, t2_seq[i]);
         chk($sformatf("t2_busy_%0d", i), busy, 1);
         chk($sformatf("t2_done_%0d", i), done, 0);
         if (i < 12) begin
            chk($sformatf("t2_dir_%0d", i), cbus.ctr_dir, t2_dir[i]);
            chk($sformatf("t2_nload_%0d", i), cbus.ctr_load, 0);
         end
         if (i == 3) begin
            lo_lim = 4'd0; hi_lim = 4'd9; n_sweeps = 4'd7;
         end
         start = (i == 5);
      end
      chk("t2_final_load", cbus.ctr_load, 1);
      chk("t2_final_ldata", cbus.ctr_ldata, 2);
      tick();
      chk("t2_done", done, 1);
      chk("t2_busy_low", busy, 0);
      chk("t2_sweep_cnt", sweep_cnt, 2);
      chk("t2_ctr_hold", cbus.ctr_val, 2);
      tick();
      chk("t2_done_pulse", done, 0);
      chk("t2_ctr_idle", cbus.ctr_val, 2);

      // T1: reset in the middle of a run
      launch(4'd2, 4'd5, 4'd2);
      for (int i = 0; i < 8; i++) tick();
      chk("t1_ctr_pre", cbus.ctr_val, 3);
      chk("t1_cnt_pre", sweep_cnt, 1);
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("t1_busy", busy, 0);
      chk("t1_done", done, 0);
      chk("t1_sweep_cnt", sweep_cnt, 0);
      chk("t1_load", cbus.ctr_load, 1);
      tick();
      chk("t1_ctr_hold", cbus.ctr_val, 0);
      chk("t1_idle", busy, 0);

      // T3: illegal limits and zero sweeps
      launch(4'd5, 4'd5, 4'd1);
      chk("t3_err_eq", err, 1);
      chk("t3_busy_eq", busy, 0);
      chk("t3_ctr_eq", cbus.ctr_val, 0);
      tick();
      chk("t3_err_pulse", err, 0);
      launch(4'd7, 4'd3, 4'd1);
      chk("t3_err_inv", err, 1);
      chk("t3_busy_inv", busy, 0);
      tick();
      launch(4'd1, 4'd4, 4'd0);
      chk("t3_n0_done", done, 1);
      chk("t3_n0_err", err, 0);
      chk("t3_n0_busy", busy, 0);
      tick();
      chk("t3_n0_pulse", done, 0);

      // T4: full range, turn at 15 without wrapping
      launch(4'd0, 4'd15, 4'd1);
      for (int i = 0; i < 31; i++) begin
         tick();
         chk($sformatf("t4_ctr_%0d", i), cbus.ctr_val, (i <= 15) ? i : 30 - i);
         chk($sformatf("t4_done_%0d", i), done, 0);
      end
      tick();
      chk("t4_done", done, 1);
      chk("t4_sweep_cnt", sweep_cnt, 1);
      chk("t4_ctr_end", cbus.ctr_val, 0);

      // T5: abort while counting up at 4
      launch(4'd2, 4'd5, 4'd3);
      tick();
      tick();
      tick();
      chk("t5_ctr", cbus.ctr_val, 4);
      chk("t5_dir", cbus.ctr_dir, 1);
      abort = 1'b1;
      #1;
      chk("t5_abort_load", cbus.ctr_load, 1);
      chk("t5_abort_ldata", cbus.ctr_ldata, 4);
      tick();
      abort = 1'b0;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_sweep_cnt", sweep_cnt, 0);
      chk("t5_ctr_hold", cbus.ctr_val, 4);
      tick();
      chk("t5_ctr_hold2", cbus.ctr_val, 4);
      chk("t5_no_done", done, 0);

      // Corrupted counter value mid-run
      launch(4'd2, 4'd5, 4'd1);
      tick();
      chk("cor_ctr", cbus.ctr_val, 2);
      corrupt_val = 4'd9;
      corrupt     = 1'b1;
      tick();
      corrupt = 1'b0;
      #1;
      chk("cor_val", cbus.ctr_val, 9);
      chk("cor_load", cbus.ctr_load, 1);
      tick();
      chk("cor_err", err, 1);
      chk("cor_busy", busy, 0);
      chk("cor_done", done, 0);

`ifdef SWEEP_PAUSE_EN
      // T6: three-cycle pause at 3 on the way down
      launch(4'd2, 4'd5, 4'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("t6_ctr_%0d", i), cbus.ctr_val, t6_seq[i]);
         chk($sformatf("t6_done_%0d", i), done, 0);
         pause = (i >= 5) && (i <= 7);
      end
      tick();
      chk("t6_done", done, 1);
      chk("t6_sweep_cnt", sweep_cnt, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
